cdb_writeback_arbiter: RTL and testbench
========================================

Name: cdb_writeback_arbiter

Overview:
- Responder side of the execution-unit writeback handshake (ALU, load buffer, address-calc unit).
- Each unit holds a finished result with `*_wr_valid` and waits for `*_wr_written`; this block grants at most one unit per cycle onto the common data bus (CDB).
- Granted result is registered and broadcast to ROB and reservation stations the next cycle.
- Round-robin fairness, flush on branch misprediction, backpressure from ROB.

Parameters:
- N_SRC, 3, number of writeback sources; index 0=ALU, 1=LB, 2=ACU.
- TAG_W, 5, ROB tag width (32-entry ROB).
- XLEN, 32, result data width.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- src_wr_valid  input  N_SRC  source i holds a result awaiting writeback.
- src_wr_tag  input  N_SRC*TAG_W  ROB tag of source i, slice [i*TAG_W +: TAG_W].
- src_wr_value  input  N_SRC*XLEN  result of source i, slice [i*XLEN +: XLEN].
- cdb_stall  input  1  ROB cannot accept a broadcast this cycle.
- flush  input  1  branch misprediction; discard everything in flight.
- src_wr_written  output  N_SRC  one-hot (or zero) grant, combinational, same cycle as valid.
- cdb_valid  output  1  registered broadcast valid.
- cdb_tag  output  TAG_W  registered broadcast ROB tag.
- cdb_value  output  XLEN  registered broadcast value.
- cdb_src  output  2  index of the source that produced the current broadcast.

Behaviour:
- Reset (async, on assertion):
  - cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0.
  - rr_ptr=0.
  - src_wr_written is combinational, so it reads 0 while reset is high.
- Grant logic (combinational):
  - grant_en = ~reset & ~flush & ~cdb_stall.
  - When grant_en=1: scan sources in order rr_ptr, rr_ptr+1, …, wrapping mod N_SRC; the first with src_wr_valid=1 gets src_wr_written[i]=1. All others stay 0.
  - When grant_en=0 or no source is valid: src_wr_written=0.
- Handshake:
  - A source treats written=1 as "result consumed this cycle" and may present a new result next cycle.
  - A source must hold valid, tag and value stable until written.
  - The arbiter never grants a source whose valid=0.
- CDB register, updated at posedge:
  - flush=1: cdb_valid<=0. Tag, value and src are don't-care.
  - Else if cdb_stall=1: hold all CDB outputs unchanged.
  - Else if a grant was given to source i: cdb_valid<=1; cdb_tag/cdb_value<=slice i; cdb_src<=i.
  - Else: cdb_valid<=0.
- Latency: a result granted in cycle t is visible on the CDB in cycle t+1, for exactly one cycle unless cdb_stall holds it.
- Round-robin pointer:
  - On a grant to source i, rr_ptr<=(i+1) mod N_SRC at posedge.
  - No grant: rr_ptr unchanged.
  - Flush does not reset rr_ptr.
- Fairness: with all sources continuously valid and no stall, grants rotate 0,1,2,0,…. Worst-case wait for any valid source is N_SRC-1 cycles of non-stalled bus.
- Simultaneous events:
  - flush and cdb_stall together: flush wins; CDB is cleared, no grant.
  - Source valid rises in the same cycle rr_ptr points to it: granted that cycle.
- Reset mid-operation: a broadcast in flight is dropped immediately (async). Sources keep holding results and are re-arbitrated from rr_ptr=0 after reset deasserts.
- Width rules: rr_ptr and cdb_src are 2 bits for N_SRC≤4. Modulo wrap is implemented as compare-to-(N_SRC-1) then zero, not bit truncation.

Test Plan:
- Reset then all three valid (tags 3, 7, 9; values 0xA, 0xB, 0xC), no stall:
  - written = 001, 010, 100 on consecutive cycles.
  - cdb_tag = 3, 7, 9 one cycle later, each with cdb_valid=1.
- Only LB valid (tag 12, value 0xDEAD) with rr_ptr=0:
  - written=010 the same cycle.
  - Next cycle cdb_valid=1, cdb_tag=12, cdb_value=0xDEAD, cdb_src=1; rr_ptr becomes 2.
- ALU granted (tag 4), then cdb_stall=1 for 3 cycles with LB valid:
  - CDB holds tag 4 with cdb_valid=1 for all 3 cycles, written=000.
  - After stall drops, LB is granted.
- flush in the cycle ACU is valid (tag 20) and a broadcast (tag 5) is on the CDB:
  - written=000; next cycle cdb_valid=0.
  - ACU still valid; granted the cycle after flush deasserts.
- Assert reset asynchronously mid-cycle while cdb_valid=1:
  - cdb_valid drops before the next clock edge.
  - After deassertion with ALU and ACU valid, ALU is granted first (rr_ptr=0).
- No sources valid for 5 cycles:
  - written=000, cdb_valid=0 throughout, rr_ptr unchanged.

Source files
------------

// File: rtl/cdb_writeback_arbiter.sv
// cdb_writeback_arbiter: round-robin writeback grant onto a registered common data bus
module cdb_writeback_arbiter #(
  parameter int N_SRC = 3,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [N_SRC-1:0]       src_wr_valid_i,
  input  logic [N_SRC*TAG_W-1:0] src_wr_tag_i,
  input  logic [N_SRC*XLEN-1:0]  src_wr_value_i,
  input  logic                   cdb_stall_i,
  input  logic                   flush_i,
  output logic [N_SRC-1:0]       src_wr_written_o,
  output logic                   cdb_valid_o,
  output logic [TAG_W-1:0]       cdb_tag_o,
  output logic [XLEN-1:0]        cdb_value_o,
  output logic [1:0]             cdb_src_o
);
  localparam logic [2:0] NS   = 3'(N_SRC);
  localparam logic [1:0] LAST = 2'(N_SRC-1);
  logic             grant_en, gnt;
  logic [2:0]       sum;
  logic [1:0]       idx, gidx, rr_q, rr_d, cdb_src_q, cdb_src_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]  cdb_value_q, cdb_value_d;
  always_comb begin
    grant_en = ~reset_i & ~flush_i & ~cdb_stall_i;
    gnt = 1'b0;
    gidx = '0;
    sum = '0;
    idx = '0;
    src_wr_written_o = '0;
    for (int k = 0; k < N_SRC; k++) begin
      sum = {1'b0, rr_q} + 3'(k);
      idx = 2'(sum >= NS ? sum - NS : sum);
      if (grant_en && !gnt && src_wr_valid_i[idx]) begin
        gnt = 1'b1;
        gidx = idx;
      end
    end
    if (gnt) src_wr_written_o[gidx] = 1'b1;
    rr_d = gnt ? (gidx == LAST ? 2'd0 : gidx + 2'd1) : rr_q;
    // a grant already implies no flush and no stall, so payload only moves on gnt
    cdb_valid_d = flush_i ? 1'b0 : cdb_stall_i ? cdb_valid_q : gnt;
    cdb_tag_d   = gnt ? src_wr_tag_i[gidx*TAG_W +: TAG_W] : cdb_tag_q;
    cdb_value_d = gnt ? src_wr_value_i[gidx*XLEN +: XLEN] : cdb_value_q;
    cdb_src_d   = gnt ? gidx : cdb_src_q;
  end
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_src_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_src_q   <= cdb_src_d;
    end
  end
  assign cdb_valid_o = cdb_valid_q;
  assign cdb_tag_o   = cdb_tag_q;
  assign cdb_value_o = cdb_value_q;
  assign cdb_src_o   = cdb_src_q;
endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// tb_cdb_writeback_arbiter: directed and randomized checks against a cycle-level reference model
module tb_cdb_writeback_arbiter;
  logic        clock = 1'b0;
  logic        rst, stall, flush;
  logic [2:0]  v;
  logic [4:0]  tg [3];
  logic [31:0] vl [3];
  logic [14:0] tag_bus;
  logic [95:0] val_bus;
  logic [2:0]  written;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;
  int          tests = 0, fails = 0;
  int          m_rr;
  logic        m_cv;
  logic [4:0]  m_ctag;
  logic [31:0] m_cval;
  logic [1:0]  m_csrc;

  assign tag_bus = {tg[2], tg[1], tg[0]};
  assign val_bus = {vl[2], vl[1], vl[0]};

  cdb_writeback_arbiter dut (
    .clock_i(clock), .reset_i(rst),
    .src_wr_valid_i(v), .src_wr_tag_i(tag_bus), .src_wr_value_i(val_bus),
    .cdb_stall_i(stall), .flush_i(flush),
    .src_wr_written_o(written), .cdb_valid_o(cdb_valid),
    .cdb_tag_o(cdb_tag), .cdb_value_o(cdb_value), .cdb_src_o(cdb_src)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int exp_grant();
    int i;
    if (rst || flush || stall) return -1;
    for (int k = 0; k < 3; k++) begin
      i = (m_rr + k) % 3;
      if (v[2'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(int g);
    return (g < 0) ? 3'b000 : 3'(1 << g);
  endfunction

  task automatic model_reset();
    m_rr = 0; m_cv = 1'b0; m_ctag = '0; m_cval = '0; m_csrc = '0;
  endtask

  task automatic model_tick();
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    g = exp_grant();
    if (flush) m_cv = 1'b0;
    else if (!stall) begin
      m_cv = (g >= 0);
      if (g >= 0) begin
        m_ctag = tg[g]; m_cval = vl[g]; m_csrc = 2'(g);
      end
    end
    if (g >= 0) m_rr = (g + 1) % 3;
  endtask

  // advance one clock; the granted source retires its result after the edge
  task automatic adv();
    int g;
    g = exp_grant();
    model_tick();
    @(posedge clock); #1;
    if (g >= 0) v[2'(g)] = 1'b0;
  endtask

  task automatic test_reset();
    v = 3'b111;
    for (int i = 0; i < 3; i++) begin tg[i] = 5'($urandom); vl[i] = $urandom; end
    @(negedge clock);
    tests++; if (written !== 3'b000) begin fails++; $display("FAIL reset_written got=%b exp=000", written); end
    tests++; if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== 40'd0) begin
      fails++; $display("FAIL reset_cdb got v=%b t=%0d d=%h s=%0d exp all zero", cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    @(posedge clock); #1;
    rst = 1'b0; v = 3'b000;
  endtask

  task automatic test_rotation();
    logic [2:0] ew [3];
    logic [4:0] et [3];
    ew[0] = 3'b001; ew[1] = 3'b010; ew[2] = 3'b100;
    et[0] = 5'd3; et[1] = 5'd7; et[2] = 5'd9;
    v = 3'b111;
    tg[0] = 5'd3; tg[1] = 5'd7; tg[2] = 5'd9;
    vl[0] = 32'hA; vl[1] = 32'hB; vl[2] = 32'hC;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tests++; if (written !== ew[c]) begin fails++; $display("FAIL rot_written[%0d] got=%b exp=%b", c, written, ew[c]); end
      if (c > 0) begin
        tests++; if (cdb_valid !== 1'b1 || cdb_tag !== et[c-1]) begin
          fails++; $display("FAIL rot_cdb[%0d] got v=%b t=%0d exp v=1 t=%0d", c, cdb_valid, cdb_tag, et[c-1]);
        end
      end
      adv();
    end
    @(negedge clock);
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd9 || cdb_value !== 32'hC) begin
      fails++; $display("FAIL rot_cdb_last got v=%b t=%0d d=%h exp v=1 t=9 d=c", cdb_valid, cdb_tag, cdb_value);
    end
    adv();
  endtask

  task automatic test_single_lb();
    v = 3'b010; tg[1] = 5'd12; vl[1] = 32'hDEAD;
    @(negedge clock);
    tests++; if (written !== 3'b010) begin fails++; $display("FAIL lb_written got=%b exp=010", written); end
    adv();
    @(negedge clock);
    tests++; if ({cdb_valid, cdb_tag, cdb_value, cdb_src} !== {1'b1, 5'd12, 32'hDEAD, 2'd1}) begin
      fails++; $display("FAIL lb_cdb got v=%b t=%0d d=%h s=%0d exp v=1 t=12 d=dead s=1", cdb_valid, cdb_tag, cdb_value, cdb_src);
    end
    adv();
    v = 3'b111;
    @(negedge clock);
    tests++; if (written !== 3'b100) begin fails++; $display("FAIL lb_rr_next got=%b exp=100", written); end
    adv();
    v = 3'b000;
  endtask

  task automatic test_stall();
    v = 3'b001; tg[0] = 5'd4; vl[0] = 32'h44;
    @(negedge clock);
    tests++; if (written !== 3'b001) begin fails++; $display("FAIL stall_alu_written got=%b exp=001", written); end
    adv();
    v[1] = 1'b1; tg[1] = 5'd17; vl[1] = 32'h1717; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      tests++; if (written !== 3'b000 || cdb_valid !== 1'b1 || cdb_tag !== 5'd4) begin
        fails++; $display("FAIL stall_hold[%0d] got w=%b v=%b t=%0d exp w=000 v=1 t=4", c, written, cdb_valid, cdb_tag);
      end
      adv();
    end
    stall = 1'b0;
    @(negedge clock);
    tests++; if (written !== 3'b010) begin fails++; $display("FAIL stall_release got=%b exp=010", written); end
    adv();
    @(negedge clock);
    tests++; if (cdb_valid !== 1'b1 || cdb_tag !== 5'd17 || cdb_src !== 2'd1) begin
      fails++; $display("FAIL stall_lb_cdb got v=%b t=%0d s=%0d exp v=1 t=17 s=1", cdb_valid, cdb_tag, cdb_src);
    end
  endtask

  task automatic test_flush();
    v = 3'b001; tg[0] = 5'd5; vl[0] = 32'h55;
    @(negedge clock);
    tests++; if (written !== 3'b001) begin fails++; $display("FAIL flush_setup got=%b exp=001", written); end
    adv();
    v[2] = 1'b1; tg[2] = 5'd20; vl[2] = $urandom; flush = 1'b1;
    @(negedge clock);
    tests++; if (written !== 3'b000 || cdb_valid !== 1'b1 || cdb_tag !== 5'd5) begin
      fails++; $display("FAIL flush_cycle got w=%b v=%b t=%0d exp w=000 v=1 t=5", written, cdb_valid, cdb_tag);
    end
    adv();
    flush = 1'b0;
    @(negedge clock);
    tests++; if (cdb_valid !== 1'b0) begin fails++; $display("FAIL flush_cleared got v=%b exp 0", cdb_valid); end
    tests++; if (written !== 3'b100) begin fails++; $display("FAIL flush_acu_after got=%b exp=100", written); end
    adv();
    v = 3'b001; tg[0] = 5'd6; stall = 1'b1; flush = 1'b1;
    @(negedge clock);
    tests++; if (written !== 3'b000 || cdb_valid !== 1'b1 || cdb_tag !== 5'd20 || cdb_src !== 2'd2) begin
      fails++; $display("FAIL flush_stall_cycle got w=%b v=%b t=%0d s=%0d exp w=000 v=1 t=20 s=2", written, cdb_valid, cdb_tag, cdb_src);
    end
    adv();
    stall = 1'b0; flush = 1'b0;
    @(negedge clock);
    tests++; if (cdb_valid !== 1'b0 || written !== 3'b001) begin
      fails++; $display("FAIL flush_beats_stall got v=%b w=%b exp v=0 w=001", cdb_valid, written);
    end
    adv();
  endtask

  task automatic test_async_reset();
    v = 3'b001; tg[0] = 5'd11; vl[0] = 32'h1111;
    @(negedge clock);
    adv();
    tests++; if (cdb_valid !== 1'b1) begin fails++; $display("FAIL areset_pre got v=%b exp 1", cdb_valid); end
    v = 3'b101; tg[0] = 5'd1; tg[2] = 5'd2; vl[0] = 32'h10; vl[2] = 32'h20;
    #2 rst = 1'b1;
    #1;
    tests++; if (cdb_valid !== 1'b0 || cdb_tag !== 5'd0) begin
      fails++; $display("FAIL areset_drop got v=%b t=%0d exp v=0 t=0", cdb_valid, cdb_tag);
    end
    model_reset();
    @(negedge clock);
    tests++; if (written !== 3'b000) begin fails++; $display("FAIL areset_written got=%b exp=000", written); end
    @(posedge clock); #1;
    rst = 1'b0;
    @(negedge clock);
    tests++; if (written !== 3'b001) begin fails++; $display("FAIL areset_alu_first got=%b exp=001", written); end
    adv();
    @(negedge clock);
    tests++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_tag !== 5'd1 || written !== 3'b100) begin
      fails++; $display("FAIL areset_after got v=%b s=%0d t=%0d w=%b exp v=1 s=0 t=1 w=100", cdb_valid, cdb_src, cdb_tag, written);
    end
    adv();
    v = 3'b000;
  endtask

  task automatic test_idle();
    int saved;
    adv();
    saved = m_rr;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      tests++; if (written !== 3'b000 || cdb_valid !== 1'b0) begin
        fails++; $display("FAIL idle[%0d] got w=%b v=%b exp w=000 v=0", c, written, cdb_valid);
      end
      adv();
    end
    v = 3'b111;
    @(negedge clock);
    tests++; if (written !== onehot(saved)) begin fails++; $display("FAIL idle_rr got=%b exp=%b", written, onehot(saved)); end
    adv();
    v = 3'b000;
    adv();
  endtask

  task automatic test_random();
    logic [2:0] ew;
    for (int c = 0; c < 400; c++) begin
      rst   = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if (rst) model_reset();
      for (int i = 0; i < 3; i++)
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1; tg[i] = 5'($urandom); vl[i] = $urandom;
        end
      @(negedge clock);
      ew = onehot(exp_grant());
      tests++; if (written !== ew) begin fails++; $display("FAIL rand_written[%0d] got=%b exp=%b", c, written, ew); end
      tests++; if (cdb_valid !== m_cv) begin fails++; $display("FAIL rand_valid[%0d] got=%b exp=%b", c, cdb_valid, m_cv); end
      if (m_cv) begin
        tests++; if ({cdb_tag, cdb_value, cdb_src} !== {m_ctag, m_cval, m_csrc}) begin
          fails++; $display("FAIL rand_payload[%0d] got t=%0d d=%h s=%0d exp t=%0d d=%h s=%0d", c, cdb_tag, cdb_value, cdb_src, m_ctag, m_cval, m_csrc);
        end
      end
      adv();
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0; v = 3'b000;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; v = 3'b000;
    for (int i = 0; i < 3; i++) begin tg[i] = '0; vl[i] = '0; end
    model_reset();
    #1;
    test_reset();
    test_rotation();
    test_single_lb();
    test_stall();
    test_flush();
    test_async_reset();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
